// File: rtl/ifu_prefetch.sv
`default_nettype none
// =============================================================================
// Module   : ifu_prefetch
// Brief    : RV32IC fetch unit with a word prefetch queue that reassembles
//            16/32-bit instructions at any halfword alignment.
// Revision : 1.0 - initial release
// =============================================================================
module ifu_prefetch #(
  parameter int            AW       = 32,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          jump,
  input  logic [AW-1:0] jump_op1,
  input  logic [AW-1:0] jump_op2,
  output logic          mem_cs,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata,
  output logic          insr_valid,
  input  logic          insr_ready,
  output logic [31:0]   insr,
  output logic [AW-1:0] insr_pc,
  output logic          insr_is16
);

  localparam int            PW      = $clog2(DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        r_state;
  logic [AW-3:0] r_faddr;
  logic [31:0]   r_q [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_off;
  logic          r_resp;   // read issued last cycle returns now and is wanted
  logic [AW-1:0] r_pc;

  logic          w_run;
  logic          w_issue;
  logic          w_is16;
  logic          w_need2;
  logic          w_valid;
  logic          w_hs;
  logic          w_pop;
  logic          w_jmp;
  logic [PW-1:0] w_head1;
  logic [31:0]   w_word0;
  logic [31:0]   w_word1;
  logic [15:0]   w_hw;
  logic [31:0]   w_insr;
  logic [AW-1:0] w_sum;
  logic [AW-1:0] w_target;

  assign w_run    = (r_state == S_RUN);
  // Credit counts the returning word so the queue can never overflow.
  assign w_issue  = w_run && ((r_count + CW'(r_resp)) < c_depth);
  assign w_jmp    = w_run && jump;

  assign w_head1  = r_head + PW'(1);
  assign w_word0  = r_q[r_head];
  assign w_word1  = r_q[w_head1];
  assign w_hw     = r_off ? w_word0[31:16] : w_word0[15:0];
  assign w_is16   = (w_hw[1:0] != 2'b11);
  assign w_need2  = !w_is16 && r_off;
  assign w_valid  = w_run && (w_need2 ? (r_count >= CW'(2)) : (r_count != '0));
  assign w_hs     = w_valid && insr_ready;
  // A 16-bit instruction in the low half leaves the word for its neighbour.
  assign w_pop    = w_hs && !(w_is16 && !r_off);

  assign w_sum    = jump_op1 + jump_op2;
  assign w_target = w_sum & ~AW'(1);

  always_comb begin
    w_insr = '0;
    if (w_valid) begin
      if (w_is16)
        w_insr = {16'h0000, w_hw};
      else if (r_off)
        w_insr = {w_word1[15:0], w_word0[31:16]};
      else
        w_insr = w_word0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_faddr <= RESET_PC[AW-1:2];
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_off   <= RESET_PC[1];
      r_resp  <= 1'b0;
      r_pc    <= RESET_PC;
    end else begin
      if (r_state == S_IDLE && start)
        r_state <= S_RUN;

      r_resp <= w_issue;
      if (w_issue)
        r_faddr <= r_faddr + (AW-2)'(1);

      if (w_jmp) begin
        // Flush; the read issued this cycle returns next cycle and is ignored.
        r_faddr <= w_target[AW-1:2];
        r_off   <= w_target[1];
        r_pc    <= w_target;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_resp  <= 1'b0;
      end else begin
        if (r_resp) begin
          r_q[r_tail] <= mem_rdata;
          r_tail      <= r_tail + PW'(1);
        end
        if (w_hs) begin
          r_pc <= r_pc + (w_is16 ? AW'(2) : AW'(4));
          if (w_is16)
            r_off <= ~r_off;
        end
        if (w_pop)
          r_head <= w_head1;
        r_count <= r_count + CW'(r_resp) - CW'(w_pop);
      end
    end
  end

  assign mem_cs     = w_issue;
  assign mem_addr   = {2'b00, r_faddr};
  assign insr_valid = w_valid;
  assign insr       = w_insr;
  assign insr_pc    = r_pc;
  assign insr_is16  = w_valid && w_is16;

endmodule
`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
`default_nettype none
// =============================================================================
// Module   : tb_ifu_prefetch
// Brief    : Directed self-checking bench for ifu_prefetch.
// Revision : 1.0 - initial release
// =============================================================================
module tb_ifu_prefetch;

  logic        clk;
  logic        rst;
  logic        start;
  logic        jump;
  logic [31:0] jump_op1;
  logic [31:0] jump_op2;
  logic        mem_cs;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        insr_valid;
  logic        insr_ready;
  logic [31:0] insr;
  logic [31:0] insr_pc;
  logic        insr_is16;

  int checks;
  int failures;

  logic [31:0] mem [0:8191];

  ifu_prefetch #(.AW(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .jump       (jump),
    .jump_op1   (jump_op1),
    .jump_op2   (jump_op2),
    .mem_cs     (mem_cs),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .insr_valid (insr_valid),
    .insr_ready (insr_ready),
    .insr       (insr),
    .insr_pc    (insr_pc),
    .insr_is16  (insr_is16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: data one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_cs)
      mem_rdata <= mem[mem_addr[12:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({mem_cs, mem_addr, insr_valid, insr, insr_pc, insr_is16} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values got cs=%0b addr=%h v=%0b insr=%h pc=%h is16=%0b exp all zero",
               mem_cs, mem_addr, insr_valid, insr, insr_pc, insr_is16);
    end
    // jump must be ignored while idle
    jump = 1'b1; jump_op1 = 32'h100; jump_op2 = 32'h0;
    tick();
    jump = 1'b0;
    tick();
    checks++;
    if ({mem_cs, mem_addr, insr_pc} !== {1'b0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL idle_jump_ignored got cs=%0b addr=%h pc=%h exp cs=0 addr=0 pc=0", mem_cs, mem_addr, insr_pc);
    end
  endtask

  task automatic test_start();
    start = 1'b1;
    tick();                                  // T+1
    start = 1'b0;
    checks++;
    if ({mem_cs, mem_addr, insr_valid} !== {1'b1, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL start_t1 got cs=%0b addr=%h v=%0b exp cs=1 addr=0 v=0", mem_cs, mem_addr, insr_valid);
    end
    tick();                                  // T+2
    checks++;
    if ({mem_cs, mem_addr, insr_valid} !== {1'b1, 32'h1, 1'b0}) begin
      failures++;
      $display("FAIL start_t2 got cs=%0b addr=%h v=%0b exp cs=1 addr=1 v=0", mem_cs, mem_addr, insr_valid);
    end
    tick();                                  // T+3
    checks++;
    if ({insr_valid, insr_pc, insr, insr_is16} !== {1'b1, 32'h0, 32'h00000013, 1'b0}) begin
      failures++;
      $display("FAIL start_t3_nop got v=%0b pc=%h insr=%h is16=%0b exp v=1 pc=0 insr=00000013 is16=0",
               insr_valid, insr_pc, insr, insr_is16);
    end
    tick();
    checks++;
    if ({insr_valid, insr_pc, insr, insr_is16} !== {1'b1, 32'h4, 32'h00004501, 1'b1}) begin
      failures++;
      $display("FAIL start_cli_lo got v=%0b pc=%h insr=%h is16=%0b exp v=1 pc=4 insr=00004501 is16=1",
               insr_valid, insr_pc, insr, insr_is16);
    end
    tick();
    checks++;
    if ({insr_valid, insr_pc, insr, insr_is16} !== {1'b1, 32'h6, 32'h00004501, 1'b1}) begin
      failures++;
      $display("FAIL start_cli_hi got v=%0b pc=%h insr=%h is16=%0b exp v=1 pc=6 insr=00004501 is16=1",
               insr_valid, insr_pc, insr, insr_is16);
    end
    tick();
    checks++;
    if ({insr_valid, insr_pc, insr, insr_is16} !== {1'b1, 32'h8, 32'h00A00093, 1'b0}) begin
      failures++;
      $display("FAIL start_addi got v=%0b pc=%h insr=%h is16=%0b exp v=1 pc=8 insr=00a00093 is16=0",
               insr_valid, insr_pc, insr, insr_is16);
    end
  endtask

  task automatic test_jump_unaligned16();
    jump = 1'b1; jump_op1 = 32'h236; jump_op2 = 32'h0;
    tick();                                  // J+1
    jump = 1'b0;
    checks++;
    if ({insr_valid, mem_cs, mem_addr} !== {1'b0, 1'b1, 32'h8D}) begin
      failures++;
      $display("FAIL ju16_j1 got v=%0b cs=%0b addr=%h exp v=0 cs=1 addr=0000008d", insr_valid, mem_cs, mem_addr);
    end
    tick();                                  // J+2
    checks++;
    if (insr_valid !== 1'b0) begin
      failures++;
      $display("FAIL ju16_j2_valid got %0b exp 0", insr_valid);
    end
    tick();                                  // J+3
    checks++;
    if ({insr_valid, insr_pc, insr, insr_is16} !== {1'b1, 32'h236, 32'h00004505, 1'b1}) begin
      failures++;
      $display("FAIL ju16_first got v=%0b pc=%h insr=%h is16=%0b exp v=1 pc=236 insr=00004505 is16=1",
               insr_valid, insr_pc, insr, insr_is16);
    end
    tick();
    checks++;
    if ({insr_valid, insr_pc, insr, insr_is16} !== {1'b1, 32'h238, 32'h00004509, 1'b1}) begin
      failures++;
      $display("FAIL ju16_next got v=%0b pc=%h insr=%h is16=%0b exp v=1 pc=238 insr=00004509 is16=1",
               insr_valid, insr_pc, insr, insr_is16);
    end
  endtask

  task automatic test_jump_aligned16();
    jump = 1'b1; jump_op1 = 32'h50; jump_op2 = 32'h4;
    tick();
    jump = 1'b0;
    checks++;
    if (insr_valid !== 1'b0) begin
      failures++;
      $display("FAIL ja16_j1_valid got %0b exp 0", insr_valid);
    end
    tick();
    checks++;
    if (insr_valid !== 1'b0) begin
      failures++;
      $display("FAIL ja16_j2_valid got %0b exp 0", insr_valid);
    end
    tick();
    checks++;
    if ({insr_valid, insr_pc, insr, insr_is16} !== {1'b1, 32'h54, 32'h00004515, 1'b1}) begin
      failures++;
      $display("FAIL ja16_first got v=%0b pc=%h insr=%h is16=%0b exp v=1 pc=54 insr=00004515 is16=1",
               insr_valid, insr_pc, insr, insr_is16);
    end
    tick();
    checks++;
    if ({insr_valid, insr_pc, insr, insr_is16} !== {1'b1, 32'h56, 32'h00004511, 1'b1}) begin
      failures++;
      $display("FAIL ja16_next got v=%0b pc=%h insr=%h is16=%0b exp v=1 pc=56 insr=00004511 is16=1",
               insr_valid, insr_pc, insr, insr_is16);
    end
  endtask

  task automatic test_jump_unaligned32();
    // 0x400 + 0xFFFFFFD6 wraps to 0x3D6
    jump = 1'b1; jump_op1 = 32'h400; jump_op2 = 32'hFFFFFFD6;
    tick();
    jump = 1'b0;
    checks++;
    if ({insr_valid, mem_addr} !== {1'b0, 32'hF5}) begin
      failures++;
      $display("FAIL ju32_j1 got v=%0b addr=%h exp v=0 addr=000000f5", insr_valid, mem_addr);
    end
    tick();
    tick();                                  // J+3: only one word present
    checks++;
    if (insr_valid !== 1'b0) begin
      failures++;
      $display("FAIL ju32_j3_valid got %0b exp 0", insr_valid);
    end
    tick();                                  // J+4
    checks++;
    if ({insr_valid, insr_pc, insr, insr_is16} !== {1'b1, 32'h3D6, 32'h00A00513, 1'b0}) begin
      failures++;
      $display("FAIL ju32_straddle got v=%0b pc=%h insr=%h is16=%0b exp v=1 pc=3d6 insr=00a00513 is16=0",
               insr_valid, insr_pc, insr, insr_is16);
    end
    tick();
    checks++;
    if ({insr_valid, insr_pc, insr, insr_is16} !== {1'b1, 32'h3DA, 32'h00004529, 1'b1}) begin
      failures++;
      $display("FAIL ju32_next got v=%0b pc=%h insr=%h is16=%0b exp v=1 pc=3da insr=00004529 is16=1",
               insr_valid, insr_pc, insr, insr_is16);
    end
  endtask

  task automatic test_jump_aligned32_and_same_cycle();
    // 0x6015 has bit 0 forced low: target 0x6014
    jump = 1'b1; jump_op1 = 32'h6000; jump_op2 = 32'h15;
    tick();
    jump = 1'b0;
    checks++;
    if ({insr_valid, mem_addr} !== {1'b0, 32'h1805}) begin
      failures++;
      $display("FAIL ja32_j1 got v=%0b addr=%h exp v=0 addr=00001805", insr_valid, mem_addr);
    end
    tick();
    tick();                                  // J+3
    checks++;
    if ({insr_valid, insr_pc, insr, insr_is16} !== {1'b1, 32'h6014, 32'h00B00593, 1'b0}) begin
      failures++;
      $display("FAIL ja32_first got v=%0b pc=%h insr=%h is16=%0b exp v=1 pc=6014 insr=00b00593 is16=0",
               insr_valid, insr_pc, insr, insr_is16);
    end
    tick();
    checks++;
    if ({insr_valid, insr_pc, insr, insr_is16} !== {1'b1, 32'h6018, 32'h00C00613, 1'b0}) begin
      failures++;
      $display("FAIL ja32_next got v=%0b pc=%h insr=%h is16=%0b exp v=1 pc=6018 insr=00c00613 is16=0",
               insr_valid, insr_pc, insr, insr_is16);
    end
    // handshake of 0x6018 and jump to 0x54 in the same cycle
    jump = 1'b1; jump_op1 = 32'h54; jump_op2 = 32'h0;
    tick();
    jump = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      checks++;
      if (insr_valid !== 1'b0) begin
        failures++;
        $display("FAIL samecyc_flush_k%0d got v=%0b pc=%h exp v=0", i, insr_valid, insr_pc);
      end
      tick();
    end
    checks++;
    if ({insr_valid, insr_pc, insr} !== {1'b1, 32'h54, 32'h00004515}) begin
      failures++;
      $display("FAIL samecyc_target got v=%0b pc=%h insr=%h exp v=1 pc=54 insr=00004515",
               insr_valid, insr_pc, insr);
    end
  endtask

  task automatic test_backpressure();
    int          cs_cnt;
    logic [31:0] wa;
    logic [31:0] exp_insr;
    cs_cnt = 0;
    insr_ready = 1'b0;
    jump = 1'b1; jump_op1 = 32'h3FF; jump_op2 = 32'h1;
    tick();
    jump = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (mem_cs)
        cs_cnt++;
      if (i >= 3) begin
        checks++;
        if ({insr_valid, insr_pc, insr, insr_is16} !== {1'b1, 32'h400, 32'h00000401, 1'b1}) begin
          failures++;
          $display("FAIL bp_stable_j%0d got v=%0b pc=%h insr=%h is16=%0b exp v=1 pc=400 insr=00000401 is16=1",
                   i, insr_valid, insr_pc, insr, insr_is16);
        end
      end
      if (i < 10)
        tick();
    end
    checks++;
    if (cs_cnt !== 4) begin
      failures++;
      $display("FAIL bp_issue_count got %0d exp 4", cs_cnt);
    end
    checks++;
    if ({mem_cs, mem_addr} !== {1'b0, 32'h104}) begin
      failures++;
      $display("FAIL bp_full_idle got cs=%0b addr=%h exp cs=0 addr=00000104", mem_cs, mem_addr);
    end
    insr_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      wa = 32'h100 + 32'(k / 2);
      exp_insr = ((wa & 32'h3FF) << 2) | 32'h1 | ((k % 2 == 1) ? 32'h8000 : 32'h0);
      checks++;
      if ({insr_valid, insr_pc, insr, insr_is16} !== {1'b1, 32'h400 + 32'(2 * k), exp_insr, 1'b1}) begin
        failures++;
        $display("FAIL bp_drain_k%0d got v=%0b pc=%h insr=%h exp v=1 pc=%h insr=%h",
                 k, insr_valid, insr_pc, insr, 32'h400 + 32'(2 * k), exp_insr);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({mem_cs, mem_addr, insr_valid, insr, insr_pc, insr_is16} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL midreset_values got cs=%0b addr=%h v=%0b insr=%h pc=%h is16=%0b exp all zero",
               mem_cs, mem_addr, insr_valid, insr, insr_pc, insr_is16);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({mem_cs, mem_addr, insr_valid} !== {1'b1, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL restart_t1 got cs=%0b addr=%h v=%0b exp cs=1 addr=0 v=0", mem_cs, mem_addr, insr_valid);
    end
    tick();
    checks++;
    if (insr_valid !== 1'b0) begin
      failures++;
      $display("FAIL restart_t2_valid got %0b exp 0", insr_valid);
    end
    tick();
    checks++;
    if ({insr_valid, insr_pc, insr, insr_is16} !== {1'b1, 32'h0, 32'h00000013, 1'b0}) begin
      failures++;
      $display("FAIL restart_t3 got v=%0b pc=%h insr=%h is16=%0b exp v=1 pc=0 insr=00000013 is16=0",
               insr_valid, insr_pc, insr, insr_is16);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    start      = 1'b0;
    jump       = 1'b0;
    jump_op1   = 32'h0;
    jump_op2   = 32'h0;
    insr_ready = 1'b1;

    // Filler: two 16-bit instructions per word, tagged with the word address.
    for (int a = 0; a < 8192; a++)
      mem[a] = {4'h8, a[9:0], 2'b01, 4'h0, a[9:0], 2'b01};
    mem[0]      = 32'h00000013;
    mem[1]      = 32'h45014501;
    mem[2]      = 32'h00A00093;
    mem[13'h15] = 32'h45114515;
    mem[13'h8D] = 32'h45050001;
    mem[13'h8E] = 32'h450D4509;
    mem[13'hF5] = 32'h05130001;
    mem[13'hF6] = 32'h452900A0;
    mem[13'h1805] = 32'h00B00593;
    mem[13'h1806] = 32'h00C00613;
    mem[13'h1807] = 32'h45314535;

    test_reset();
    test_start();
    test_jump_unaligned16();
    test_jump_aligned16();
    test_jump_unaligned32();
    test_jump_aligned32_and_same_cycle();
    test_backpressure();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
